// File: rtl/exec_unit.sv
// Execute stage: register file, operand select, single-cycle ALU and an iterative
// shift-add multiplier behind a valid/ready handshake.
module exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  RegWrite,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  aluSrc,
  input  logic [3:0]            aluCtrl,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, MUL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  eq_q, eq_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mrd_q, mrd_d;
  logic                  mwe_q, mwe_d;
  logic                  meq_q, meq_d;

  logic [DATA_WIDTH-1:0] op1, op2, op2_reg, alu_res, acc_next;
  logic [SHW-1:0]        shamt;

  assign op1      = (rs1 == '0) ? '0 : regs_q[rs1];
  assign op2_reg  = (rs2 == '0) ? '0 : regs_q[rs2];
  assign op2      = aluSrc ? ImmOp : op2_reg;
  assign shamt    = op2[SHW-1:0];
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign eq        = eq_q;
  assign dbg_data  = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  always_comb begin
    alu_res = '0;
    case (aluCtrl)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = DATA_WIDTH'($signed(op1) < $signed(op2));
      4'd6:    alu_res = DATA_WIDTH'(op1 < op2);
      4'd7:    alu_res = op1 << shamt;
      4'd8:    alu_res = op1 >> shamt;
      4'd9:    alu_res = $signed(op1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    result_d    = result_q;
    eq_d        = eq_q;
    out_valid_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mrd_d       = mrd_q;
    mwe_d       = mwe_q;
    meq_d       = meq_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (aluCtrl == 4'd10) begin
            state_d  = MUL;
            mcand_d  = op1;
            mplier_d = op2;
            acc_d    = '0;
            cnt_d    = '0;
            mrd_d    = rd;
            mwe_d    = RegWrite;
            meq_d    = (op1 == op2);
          end else begin
            result_d    = alu_res;
            eq_d        = (op1 == op2);
            out_valid_d = 1'b1;
            if (RegWrite && rd != '0) regs_d[rd] = alu_res;
          end
        end
      end
      MUL: begin
        // the last iteration's sum is written back directly, so completion lands on edge k+DATA_WIDTH
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = acc_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(DATA_WIDTH - 1)) begin
          state_d     = IDLE;
          result_d    = acc_next;
          eq_d        = meq_q;
          out_valid_d = 1'b1;
          if (mwe_q && mrd_q != '0) regs_d[mrd_q] = acc_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      regs_q      <= '{default: '0};
      result_q    <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mrd_q       <= '0;
      mwe_q       <= 1'b0;
      meq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mrd_q       <= mrd_d;
      mwe_q       <= mwe_d;
      meq_q       <= meq_d;
    end
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Parametrised execute stage: register file, immediate/register operand select and ALU behind a valid/ready handshake.
- Register file is 2^ADDR_WIDTH x DATA_WIDTH, with x0 hardwired to zero.
- Single-cycle ALU ops write back at acceptance; MUL is a multi-cycle shift-add op that stalls the front end.
- Sits between decode/control and the PC/branch logic, which consumes eq.

Parameters:
DATA_WIDTH, 32, operand/register/result width (power of two, >=8)
ADDR_WIDTH, 5, register address width; register count = 2^ADDR_WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction presented
in_ready  output  1  unit can accept (high only in IDLE)
rs1  input  ADDR_WIDTH  source register 1 address
rs2  input  ADDR_WIDTH  source register 2 address
rd  input  ADDR_WIDTH  destination address
RegWrite  input  1  write result to rd
ImmOp  input  DATA_WIDTH  pre-extended immediate
aluSrc  input  1  1: op2=ImmOp, 0: op2=reg[rs2]
aluCtrl  input  4  operation select
out_valid  output  1  one-cycle pulse: result/eq updated
result  output  DATA_WIDTH  last completed result
eq  output  1  last completed op1==op2
dbg_addr  input  ADDR_WIDTH  debug read address
dbg_data  output  DATA_WIDTH  combinational reg[dbg_addr] (0 for x0)

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; out_valid=0; result=0; eq=0; all registers=0; MUL counter/accumulator=0. Reset mid-MUL aborts the op with no writeback.
- Handshake: accept when in_valid && in_ready at a rising edge; in_ready = (state==IDLE). Inputs are don't-care when not accepted.
- Operand reads: reg[rs1] and reg[rs2] are combinational; address 0 reads 0.
- aluCtrl encoding:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR
  - 5 SLT (signed, result 1/0); 6 SLTU
  - 7 SLL; 8 SRL; 9 SRA; shift amount = op2[log2(DATA_WIDTH)-1:0]
  - 10 MUL: low DATA_WIDTH bits of op1*op2
  - 11-15 reserved: result 0, single-cycle, normal writeback.
- All arithmetic wraps modulo 2^DATA_WIDTH; no overflow flag.
- Single-cycle op accepted at edge k:
  - At edge k, if RegWrite and rd!=0, reg[rd] is written; result/eq are registered and out_valid=1.
  - During cycle k..k+1, out_valid is high; it drops at edge k+1 unless another completion occurs there.
  - Back-to-back acceptance every cycle is allowed. A dependent instruction accepted at k+1 sees the new value, so no forwarding is needed.
- MUL accepted at edge k:
  - Latch op1, op2, rd, RegWrite and eq (op1==op2); go to MUL.
  - Run one shift-add iteration per edge.
  - At edge k+DATA_WIDTH: write back (RegWrite && rd!=0), register result and eq, set out_valid=1, return to IDLE.
  - in_ready is low from k through k+DATA_WIDTH-1 and high again in the cycle after completion.
- Writes to rd=0 are dropped silently.
- dbg_data reflects a write in the cycle after the write edge.
- result and eq hold between completions.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=1, dbg_data=0 for all addresses.
- ADDI chain: aluSrc=1, aluCtrl=0, rs1=0, ImmOp=5, rd=1; then rs1=1, ImmOp=0xFFFFFFFF, rd=2 on consecutive cycles -> reg1=5, reg2=4, out_valid high 2 consecutive cycles.
- Compare/shift: reg3=0x80000000 -> SRA by 4 gives 0xF8000000, SRL by 4 gives 0x08000000; SLT(reg3, 1)=1; SLTU(reg3, 1)=0; SUB 7-7 -> result 0, eq=1.
- MUL: reg1=0x0001_0003, reg2=0x0001_0002 -> in_ready low 32 cycles; result=0x0005_0006, out_valid pulses once 32 edges after accept, reg[rd] updated; in_valid held high meanwhile is not accepted.
- x0 protection: ADD with rd=0, RegWrite=1, ImmOp=9 -> result=9, out_valid=1, dbg_data(0)=0; rs1=0 reads 0.
- Reset mid-MUL at iteration 10 -> no writeback, in_ready=1 the cycle after reset deasserts, out_valid stays 0.
